core_mc: RTL

- Parametrised multi-cycle successor to the single-cycle CPUv1 core.
- Fetches RV32I-subset instructions from an external instruction memory over a request/valid handshake, executes them in an internal FSM and writes an internal register file.
- Halts at a programmable last PC.
- Sits between instruction ROM/RAM and the board top; exposes a debug register read port for test.

---
 rtl/core_mc.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/core_mc.sv
// core_mc: multi-cycle RV32I-subset core (FETCH -> EXEC -> FETCH ... -> HALT).
// Optional `define INSTRET_EN adds the instret output (wrapping retired-instruction count).
module core_mc #(
    parameter int          ADDR_W   = 10,
    parameter int          NREGS    = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              instr_req,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_valid,
    input  logic [31:0]       instr_data,
    input  logic [31:0]       last_pc,
    output logic              retire,
    output logic              halted,
    output logic              illegal,
    input  logic [4:0]        dbg_raddr,
    output logic [31:0]       dbg_rdata
`ifdef INSTRET_EN
    ,
    output logic [31:0]       instret
`endif
);

    localparam int IDX_W = $clog2(NREGS);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    state_t      r_state, w_next_state;
    logic [31:0] r_pc, r_ir;
    logic [31:0] r_regs [NREGS];
    logic        r_illegal;

    logic [6:0]  w_opcode, w_funct7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i, w_imm_u, w_imm_j, w_imm_b;
    logic [31:0] w_rs1_val, w_rs2_val, w_result, w_pc_next;
    logic        w_legal, w_we, w_use_rs1, w_use_rs2;

    // Index fits the implemented register file (upper bits zero for RV32E).
    function automatic logic idx_ok(input logic [4:0] idx);
        return (idx >> IDX_W) == 5'd0;
    endfunction

    assign w_opcode  = r_ir[6:0];
    assign w_rd      = r_ir[11:7];
    assign w_funct3  = r_ir[14:12];
    assign w_rs1     = r_ir[19:15];
    assign w_rs2     = r_ir[24:20];
    assign w_funct7  = r_ir[31:25];
    assign w_imm_i   = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_u   = {r_ir[31:12], 12'd0};
    assign w_imm_j   = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
    assign w_imm_b   = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_rs1_val = r_regs[w_rs1[IDX_W-1:0]];
    assign w_rs2_val = r_regs[w_rs2[IDX_W-1:0]];

    always_comb begin
        w_legal   = 1'b0;
        w_we      = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_result  = '0;
        w_pc_next = r_pc + 32'd4;
        case (w_opcode)
            OPC_OP_IMM: begin
                w_legal   = 1'b1;
                w_we      = 1'b1;
                w_use_rs1 = 1'b1;
                case (w_funct3)
                    3'b000: w_result = w_rs1_val + w_imm_i;
                    3'b010: w_result = {31'd0, $signed(w_rs1_val) < $signed(w_imm_i)};
                    3'b011: w_result = {31'd0, w_rs1_val < w_imm_i};
                    3'b100: w_result = w_rs1_val ^ w_imm_i;
                    3'b110: w_result = w_rs1_val | w_imm_i;
                    3'b111: w_result = w_rs1_val & w_imm_i;
                    3'b001: begin
                        w_legal  = (w_funct7 == F7_BASE);
                        w_result = w_rs1_val << w_rs2;
                    end
                    default: begin
                        w_legal = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
                        // NOTE: if/else, not ?:, because an unsigned arm would turn >>> into a logical shift.
                        if (w_funct7[5]) w_result = $signed(w_rs1_val) >>> w_rs2;
                        else             w_result = w_rs1_val >> w_rs2;
                    end
                endcase
            end
            OPC_OP: begin
                w_legal   = (w_funct7 == F7_BASE) ||
                            (w_funct7 == F7_ALT && (w_funct3 == 3'b000 || w_funct3 == 3'b101));
                w_we      = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                case (w_funct3)
                    3'b000: w_result = w_funct7[5] ? w_rs1_val - w_rs2_val : w_rs1_val + w_rs2_val;
                    3'b001: w_result = w_rs1_val << w_rs2_val[4:0];
                    3'b010: w_result = {31'd0, $signed(w_rs1_val) < $signed(w_rs2_val)};
                    3'b011: w_result = {31'd0, w_rs1_val < w_rs2_val};
                    3'b100: w_result = w_rs1_val ^ w_rs2_val;
                    3'b110: w_result = w_rs1_val | w_rs2_val;
                    3'b111: w_result = w_rs1_val & w_rs2_val;
                    default: begin
                        if (w_funct7[5]) w_result = $signed(w_rs1_val) >>> w_rs2_val[4:0];
                        else             w_result = w_rs1_val >> w_rs2_val[4:0];
                    end
                endcase
            end
            OPC_LUI: begin
                w_legal  = 1'b1;
                w_we     = 1'b1;
                w_result = w_imm_u;
            end
            OPC_AUIPC: begin
                w_legal  = 1'b1;
                w_we     = 1'b1;
                w_result = r_pc + w_imm_u;
            end
            OPC_JAL: begin
                w_legal   = 1'b1;
                w_we      = 1'b1;
                w_result  = r_pc + 32'd4;
                w_pc_next = r_pc + w_imm_j;
            end
            OPC_BRANCH: begin
                w_legal   = (w_funct3 == 3'b000) || (w_funct3 == 3'b001);
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                if ((w_rs1_val == w_rs2_val) != w_funct3[0]) w_pc_next = r_pc + w_imm_b;
            end
            default: w_legal = 1'b0;
        endcase
        if ((w_we && !idx_ok(w_rd)) || (w_use_rs1 && !idx_ok(w_rs1)) ||
            (w_use_rs2 && !idx_ok(w_rs2)))
            w_legal = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: if (instr_valid) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = (!w_legal || r_pc == last_pc) ? S_HALT : S_FETCH;
            default: w_next_state = S_HALT;
        endcase
    end

    always_comb begin
        // Gated by rst_n so a pending request drops the instant reset asserts.
        instr_req = rst_n && (r_state == S_FETCH);
        retire    = (r_state == S_EXEC) && w_legal;
        halted    = (r_state == S_HALT);
    end

    // NOTE: the register file is small enough to live in flops, so it is cleared by reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_illegal <= 1'b0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (r_state == S_FETCH && instr_valid) begin
            r_ir <= instr_data;
        end else if (r_state == S_EXEC) begin
            if (w_legal) begin
                if (w_we && w_rd != 5'd0) r_regs[w_rd[IDX_W-1:0]] <= w_result;
                r_pc <= w_pc_next & ~32'd3;
            end else begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign instr_addr = r_pc[ADDR_W+1:2];
    assign illegal    = r_illegal;
    assign dbg_rdata  = idx_ok(dbg_raddr) ? r_regs[dbg_raddr[IDX_W-1:0]] : 32'd0;

`ifdef INSTRET_EN
    logic [31:0] r_instret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_instret <= '0;
        else if (retire) r_instret <= r_instret + 32'd1;
    end

    assign instret = r_instret;
`endif

endmodule
